// File: rtl/disp_vramrd_if.sv
// AXI read-address / read-data handshake bundle between the VRAM reader and the interconnect.
// Read data travels straight to the display FIFO, so no RDATA lane is carried here.
interface disp_vramrd_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARADDR, ARLEN, ARVALID, RREADY,
    input  ARREADY, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARVALID, RREADY,
    output ARREADY, RLAST, RVALID
  );
endinterface

// File: rtl/disp_vramrd.sv
// AXI read master fetching one display frame from VRAM in fixed-length bursts,
// with bounded outstanding bursts, FIFO back-pressure and DISPON abort-with-drain.
module disp_vramrd #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BEAT_BYTES = 4,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic              ACLK,
  input  logic              ARST,
  disp_vramrd_if.master     bus,
  input  logic [1:0]        RESOL,
  input  logic              VRSTART,
  input  logic              DISPON,
  input  logic [ADDR_W-4:0] DISPADDR,
  input  logic              BUF_WREADY,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int unsigned CNT_W       = 21;
  localparam int unsigned OUT_W       = 3;
  localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int unsigned LEN_SH      = $clog2(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DRAIN} state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   issued_q, done_q, nburst_q;
  logic [CNT_W-1:0]   issued_nxt, nburst_c, pixels_c;
  logic [OUT_W-1:0]   outst_q, outst_nxt;
  logic [ADDR_W-1:0]  araddr_q;
  logic               arvalid_q, rready_q, busy_q, frame_done_q, abort_q;
  logic               ar_hs, r_last, start, abort_set, frame_done_nxt;

  // Frame size in pixels (one pixel per beat) for the selected resolution.
  always_comb begin
    pixels_c = CNT_W'(1310720);
    case (RESOL)
      2'b00:   pixels_c = CNT_W'(307200);
      2'b01:   pixels_c = CNT_W'(480000);
      2'b10:   pixels_c = CNT_W'(786432);
      default: pixels_c = CNT_W'(1310720);
    endcase
    nburst_c = pixels_c >> LEN_SH;
  end

  assign ar_hs  = arvalid_q & bus.ARREADY;
  assign r_last = bus.RVALID & rready_q & bus.RLAST & (outst_q != '0);
  assign issued_nxt = issued_q + CNT_W'(ar_hs);

  always_comb begin
    outst_nxt = outst_q;
    if (ar_hs && !r_last)      outst_nxt = outst_q + OUT_W'(1);
    else if (!ar_hs && r_last) outst_nxt = outst_q - OUT_W'(1);
  end

  // Next-state: ARVALID is only ever dropped after a handshake or on a DISPON abort.
  always_comb begin
    state_nxt = state_q;
    start     = 1'b0;
    abort_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (VRSTART && DISPON) begin
          start     = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!DISPON) begin
          abort_set = 1'b1;
          state_nxt = S_DRAIN;
        end else if (ar_hs && issued_nxt == nburst_q) begin
          state_nxt = S_DRAIN;
        end else if (ar_hs && (outst_nxt == OUT_W'(MAX_OUTST) || !BUF_WREADY)) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!DISPON) begin
          abort_set = 1'b1;
          state_nxt = S_DRAIN;
        end else if (outst_q < OUT_W'(MAX_OUTST) && BUF_WREADY) begin
          state_nxt = S_ADDR;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign frame_done_nxt = r_last && (done_q + CNT_W'(1) == nburst_q) && !abort_q &&
                          (state_q != S_IDLE);

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q      <= S_IDLE;
      issued_q     <= '0;
      done_q       <= '0;
      nburst_q     <= '0;
      outst_q      <= '0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      outst_q      <= outst_nxt;
      arvalid_q    <= (state_nxt == S_ADDR);
      rready_q     <= (state_nxt != S_IDLE) && (outst_nxt != '0);
      busy_q       <= (state_nxt != S_IDLE);
      frame_done_q <= frame_done_nxt;
      if (start) begin
        issued_q <= '0;
        done_q   <= '0;
        nburst_q <= nburst_c;
        araddr_q <= {DISPADDR, 3'b000};
        abort_q  <= 1'b0;
      end else begin
        issued_q <= issued_nxt;
        abort_q  <= abort_q | abort_set;
        if (ar_hs)  araddr_q <= araddr_q + ADDR_W'(BURST_BYTES);
        if (r_last) done_q   <= done_q + CNT_W'(1);
      end
    end
  end

  assign bus.ARADDR  = araddr_q;
  assign bus.ARLEN   = 8'(BURST_LEN - 1);
  assign bus.ARVALID = arvalid_q;
  assign bus.RREADY  = rready_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = frame_done_q;

  // A last beat with nothing outstanding means the interconnect returned data nobody asked for.
  a_no_orphan_rlast: assert property (@(posedge ACLK) disable iff (ARST)
                                      !(bus.RVALID && bus.RLAST && outst_q == '0));

endmodule
